i2s_tx_serializer: RTL and testbench
====================================

// Module: i2s_tx_serializer
// PURPOSE
// Transmit end of the codec audio path. Takes processed 16-bit samples from the stream controller's
// TX FIFO side (sclk domain), one per frame, via a request/valid handshake. Serializes them MSB-first,
// in standard I2S format, onto the codec DAC data line. BCLK/LRCK are codec-driven (slave mode) and
// oversampled by sclk.
// PARAMETERS
// DATA_W        16  sample width in bits
// SLOT_W        32  bits per channel slot (>= DATA_W); sample left-justified, zero-padded below
// MONO_DUP      1   1: right slot repeats left sample; 0: right slot all zeros
// UNDERRUN_ZERO 0   on underrun: 0 = resend last sample, 1 = send zero sample
// PORTS
// sclk      in   1       system clock (26 MHz); must be >= 8x BCLK
// rst_n     in   1       reset, synchronous, active-low
// i2s_bclk  in   1       codec bit clock, asynchronous to sclk
// i2s_lrck  in   1       codec word select; 0 = left, 1 = right; asynchronous
// frame_req out  1       1-cycle pulse: sample consumed, upstream may supply the next
// tx_valid  in   1       upstream sample strobe, 1 cycle
// tx_data   in   DATA_W  sample, qualified by tx_valid
// tx_ready  out  1       holding register empty (= ~hold_full)
// i2s_dout  out  1       serial data to codec DAC
// underrun  out  1       1-cycle pulse: left load found holding register empty
// overflow  out  1       1-cycle pulse: tx_valid while holding register full, data dropped
// BEHAVIOUR
// - Reset (rst_n=0 at sclk edge): i2s_dout=0, frame_req=0, underrun=0, overflow=0, tx_ready=1.
//   Also clears: shift register, holding reg, last-sample reg, armed flag.
// - Sync: bclk and lrck each pass through 2 flops (s1, s2), then a delay flop d.
//   bclk_fall = ~bclk_s2 & bclk_d.
//   All serializer state updates only in the sclk cycle where bclk_fall=1.
//   i2s_dout is registered and changes 3 sclk after the BCLK pin falls.
// - Channel start: at each bclk_fall, lrck_s2 is compared with lrck_prev (captured at previous bclk_fall).
//   A mismatch is a start event: to left if lrck_s2=0, to right if lrck_s2=1.
//   First bclk_fall after reset only captures lrck_prev and sets armed; no start event before armed=1.
// - Serializer, every bclk_fall:
//   - i2s_dout <= sr[SLOT_W-1].
//   - On a start event: sr <= {word, {SLOT_W-DATA_W{0}}}. Otherwise sr <= sr<<1, zero fill.
//   - Net effect: MSB appears one BCLK after the LRCK change (I2S delay).
//   - The slot's last bit is driven in the BCLK period where LRCK has already toggled.
//   - Before the first start event, i2s_dout = 0.
// - Word selection:
//   - Left start: if hold_full, word=hold, last<=hold, hold_full<=0.
//     Else word = last (UNDERRUN_ZERO=0) or 0 (=1), and underrun pulses.
//     frame_req pulses on every left start.
//   - Right start: word = last when MONO_DUP=1, else 0. No request.
// - Holding register (1 entry), per sclk cycle:
//   - tx_valid & ~hold_full: capture tx_data, hold_full<=1.
//   - tx_valid & hold_full: data dropped, overflow pulses, contents unchanged.
//   - tx_valid in the same cycle as a left start that consumes hold: consume old, capture new, hold_full stays 1, no overflow.
//   - tx_valid in the same cycle as a left start with hold empty: underrun pulses, new data captured for the next frame.
// - Latency: one frame. A sample accepted after frame_req is output at the next left slot.
// - Irregular BCLK count per slot: shorter slot truncates the word (new start event reloads);
//   longer slot outputs zeros after SLOT_W bits.
// - Reset mid-word: outputs return to reset values on the next sclk edge. Re-arm as after power-up.
// TESTING
// 1. BCLK=sclk/16, SLOT_W=32, tx_data=16'hA5C3 after frame_req.
//    -> next left slot: dout=1010_0101_1100_0011 then 16 zeros, MSB 1 BCLK after LRCK fall;
//    right slot identical (MONO_DUP=1).
// 2. No tx_valid for a frame after loading 16'h1234 -> one underrun pulse at left start,
//    slot resends 16'h1234; with UNDERRUN_ZERO=1 sends 16'h0000.
// 3. Two tx_valid (16'h1111, 16'h2222) before a left start -> overflow pulse on the second,
//    16'h1111 transmitted.
// 4. tx_valid=16'h7FFF in the exact sclk of a left start with hold empty -> underrun pulse;
//    16'h7FFF appears in the following frame.
// 5. SLOT_W=16: left=16'h8001 -> LSB '1' driven in the first BCLK of the right slot (LRCK=1);
//    right MSB follows.
// 6. rst_n low mid-slot for 1 cycle -> dout=0 next cycle; no frame_req until the second LRCK
//    change after release, and the first transmitted slot is a clean full word.

Source files
------------

// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer
// Transmit end of the codec audio path. Accepts one 16-bit sample per frame from the
// TX FIFO side through a request/valid handshake. Serializes it MSB-first in standard
// I2S format onto the DAC data line. BCLK and LRCK come from the codec and are
// oversampled by sclk.
module i2s_tx_serializer #(
    parameter int DATA_W        = 16,
    parameter int SLOT_W        = 32,
    parameter int MONO_DUP      = 1,
    parameter int UNDERRUN_ZERO = 0
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic              i2s_bclk,
    input  logic              i2s_lrck,
    output logic              frame_req,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              i2s_dout,
    output logic              underrun,
    output logic              overflow
);

    logic              bclk_s1;
    logic              bclk_s2;
    logic              bclk_d;
    logic              lrck_s1;
    logic              lrck_s2;
    logic              lrck_prev;
    logic              armed;

    logic              bclk_fall;
    logic              start_evt;
    logic              left_start;
    logic              consume;

    logic              hold_full;
    logic [DATA_W-1:0] hold_data;
    logic [DATA_W-1:0] last_sample;
    logic [DATA_W-1:0] word;
    logic [SLOT_W-1:0] load_word;
    logic [SLOT_W-1:0] sr;

    // Bring the codec clocks into the sclk domain and keep one extra bclk sample for edge detection
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            bclk_s1 <= 1'b0;
            bclk_s2 <= 1'b0;
            bclk_d  <= 1'b0;
            lrck_s1 <= 1'b0;
            lrck_s2 <= 1'b0;
        end else begin
            bclk_s1 <= i2s_bclk;
            bclk_s2 <= bclk_s1;
            bclk_d  <= bclk_s2;
            lrck_s1 <= i2s_lrck;
            lrck_s2 <= lrck_s1;
        end
    end

    assign bclk_fall  = ~bclk_s2 & bclk_d;
    assign start_evt  = bclk_fall & armed & (lrck_s2 != lrck_prev);
    assign left_start = start_evt & ~lrck_s2;
    assign consume    = left_start & hold_full;
    assign tx_ready   = ~hold_full;

    // Pick the word loaded at a channel start and left-justify it in the slot
    always_comb begin
        word      = '0;
        load_word = '0;
        if (left_start) begin
            if (hold_full) begin
                word = hold_data;
            end else if (UNDERRUN_ZERO == 0) begin
                word = last_sample;
            end
        end else if (MONO_DUP != 0) begin
            word = last_sample;
        end
        load_word[SLOT_W-1 -: DATA_W] = word;
    end

    // Track the word-select level seen at each BCLK fall; the first fall after reset only arms
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            armed     <= 1'b0;
            lrck_prev <= 1'b0;
        end else if (bclk_fall) begin
            armed     <= 1'b1;
            lrck_prev <= lrck_s2;
        end
    end

    // Shift register and output bit; a start reloads so the MSB lands one BCLK after the LRCK change
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            sr       <= '0;
            i2s_dout <= 1'b0;
        end else if (bclk_fall) begin
            i2s_dout <= sr[SLOT_W-1];
            if (start_evt) begin
                sr <= load_word;
            end else begin
                sr <= {sr[SLOT_W-2:0], 1'b0};
            end
        end
    end

    // One-entry holding register; a left start frees the slot in the same cycle a new sample may land
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (tx_valid && (!hold_full || consume)) begin
            hold_full <= 1'b1;
            hold_data <= tx_data;
        end else if (consume) begin
            hold_full <= 1'b0;
        end
    end

    // Remember the most recently transmitted fresh sample for underrun resend and mono duplication
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            last_sample <= '0;
        end else if (consume) begin
            last_sample <= hold_data;
        end
    end

    // Registered single-cycle status pulses
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            frame_req <= 1'b0;
            underrun  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            frame_req <= left_start;
            underrun  <= left_start & ~hold_full;
            overflow  <= tx_valid & hold_full & ~consume;
        end
    end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb_i2s_tx_serializer
// Drives codec-style BCLK/LRCK (BCLK = sclk/16, LRCK changing on BCLK falls) into two
// serializer configurations sharing the same stimulus: the default one (32-bit slots,
// mono duplication, resend on underrun) and an alternate one (16-bit slots, zero right
// slot, zero on underrun). Expected serial bits come from the words each slot should carry.
module tb_i2s_tx_serializer;

    logic        sclk     = 1'b0;
    logic        rst_n    = 1'b0;
    logic        bclk     = 1'b1;
    logic        lrck     = 1'b1;
    logic        tx_valid = 1'b0;
    logic [15:0] tx_data  = 16'h0000;

    logic frame_req_m, tx_ready_m, dout_m, underrun_m, overflow_m;
    logic frame_req_a, tx_ready_a, dout_a, underrun_a, overflow_a;

    i2s_tx_serializer dut_main (
        .sclk      (sclk),
        .rst_n     (rst_n),
        .i2s_bclk  (bclk),
        .i2s_lrck  (lrck),
        .frame_req (frame_req_m),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready_m),
        .i2s_dout  (dout_m),
        .underrun  (underrun_m),
        .overflow  (overflow_m)
    );

    i2s_tx_serializer #(
        .DATA_W        (16),
        .SLOT_W        (16),
        .MONO_DUP      (0),
        .UNDERRUN_ZERO (1)
    ) dut_alt (
        .sclk      (sclk),
        .rst_n     (rst_n),
        .i2s_bclk  (bclk),
        .i2s_lrck  (lrck),
        .frame_req (frame_req_a),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready_a),
        .i2s_dout  (dout_a),
        .underrun  (underrun_a),
        .overflow  (overflow_a)
    );

    always #5 sclk = ~sclk;

    int checks = 0;
    int errors = 0;

    int frM = 0, unM = 0, ovM = 0;
    int frA = 0, unA = 0, ovA = 0;

    // Count status pulses so frames can be checked by how many of each occurred
    always @(posedge sclk) begin
        if (frame_req_m) frM <= frM + 1;
        if (underrun_m)  unM <= unM + 1;
        if (overflow_m)  ovM <= ovM + 1;
        if (frame_req_a) frA <= frA + 1;
        if (underrun_a)  unA <= unA + 1;
        if (overflow_a)  ovA <= ovA + 1;
    end

    // Word carried by the slot currently ending, and its length in BCLKs
    logic [15:0] prevWordM = 16'h0;
    logic [15:0] prevWordA = 16'h0;
    int          prevLen   = 0;

    // Frame-level model of the sample path for the randomized phase
    logic        mHoldFull = 1'b0;
    logic [15:0] mHold     = 16'h0;
    logic [15:0] mLast     = 16'h0;

    typedef struct {
        int          len;
        int          mode;
        logic [15:0] d1;
        logic [15:0] d2;
        logic [15:0] expM;
        logic [15:0] expA;
        int          expUnd;
        int          expOvf;
    } vec_t;

    vec_t vecs[9];

    function automatic logic expBit(input logic [15:0] w, input int idx);
        if (idx < 0 || idx > 15) return 1'b0;
        return w[15-idx];
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // One BCLK period: fall (with LRCK update) then high half; optional tx_valid pulse
    // at a given sclk offset after the fall; samples both data lines at the end of the period
    task automatic applyStimulus(input logic lr, input int pulseOff, input logic [15:0] pdata,
                                 output logic dM, output logic dA);
        @(negedge sclk);
        bclk     = 1'b0;
        lrck     = lr;
        tx_valid = 1'b0;
        for (int k = 1; k < 16; k++) begin
            @(negedge sclk);
            if (k == 8) bclk = 1'b1;
            if (pulseOff > 0 && k == pulseOff) begin
                tx_valid = 1'b1;
                tx_data  = pdata;
            end else begin
                tx_valid = 1'b0;
            end
        end
        dM = dout_m;
        dA = dout_a;
    endtask

    task automatic runSlot(input logic lr, input int len, input logic [15:0] wM, input logic [15:0] wA,
                           input int pulseBit, input int pulseOff, input logic [15:0] pdata,
                           input int pulseBit2, input logic [15:0] pdata2, input int resetBit);
        logic dM, dA, eM, eA;
        bit   cleared = 1'b0;
        for (int j = 0; j < len; j++) begin
            if (j == pulseBit)       applyStimulus(lr, pulseOff, pdata, dM, dA);
            else if (j == pulseBit2) applyStimulus(lr, 5, pdata2, dM, dA);
            else                     applyStimulus(lr, 0, 16'h0, dM, dA);
            if (cleared) begin
                eM = 1'b0;
                eA = 1'b0;
            end else if (j == 0) begin
                eM = expBit(prevWordM, prevLen - 1);
                eA = expBit(prevWordA, prevLen - 1);
            end else begin
                eM = expBit(wM, j - 1);
                eA = expBit(wA, j - 1);
            end
            checkOutput($sformatf("dout_main lr%0d bit%0d", lr, j), dM, eM);
            checkOutput($sformatf("dout_alt lr%0d bit%0d", lr, j), dA, eA);
            if (j == resetBit) begin
                checkOutput("tx_ready_before_reset", tx_ready_m, 0);
                rst_n = 1'b0;
                @(negedge sclk);
                rst_n = 1'b1;
                checkOutput("dout_main_after_reset", dout_m, 0);
                checkOutput("dout_alt_after_reset", dout_a, 0);
                checkOutput("frame_req_after_reset", frame_req_m, 0);
                checkOutput("underrun_after_reset", underrun_m, 0);
                checkOutput("overflow_after_reset", overflow_m, 0);
                checkOutput("tx_ready_after_reset", tx_ready_m, 1);
                cleared = 1'b1;
            end
        end
        prevWordM = cleared ? 16'h0 : wM;
        prevWordA = cleared ? 16'h0 : wA;
        prevLen   = len;
    endtask

    // One frame: left slot (optional tx_valid in the left-start cycle for mode 3),
    // right slot (one or two samples supplied for modes 1 and 2), then pulse-count checks
    task automatic runFrame(input string tag, input int len, input int mode,
                            input logic [15:0] d1, input logic [15:0] d2,
                            input logic [15:0] expM, input logic [15:0] expA,
                            input int expUnd, input int expOvf);
        int fr0M = frM, un0M = unM, ov0M = ovM;
        int fr0A = frA, un0A = unA, ov0A = ovA;
        runSlot(1'b0, len, expM, expA, (mode == 3) ? 0 : -1, 2, d1, -1, 16'h0, -1);
        runSlot(1'b1, len, expM, 16'h0, (mode == 1 || mode == 2) ? 4 : -1, 5, d1,
                (mode == 2) ? 6 : -1, d2, -1);
        checkOutput({tag, " frame_req_main"}, frM - fr0M, 1);
        checkOutput({tag, " frame_req_alt"},  frA - fr0A, 1);
        checkOutput({tag, " underrun_main"},  unM - un0M, expUnd);
        checkOutput({tag, " underrun_alt"},   unA - un0A, expUnd);
        checkOutput({tag, " overflow_main"},  ovM - ov0M, expOvf);
        checkOutput({tag, " overflow_alt"},   ovA - ov0A, expOvf);
        checkOutput({tag, " tx_ready_main"},  tx_ready_m, (mode == 0) ? 1 : 0);
        checkOutput({tag, " tx_ready_alt"},   tx_ready_a, (mode == 0) ? 1 : 0);
    endtask

    initial begin
        int          fr1M, fr1A, un1M;
        int          lens[3];
        int          mode, len, und, ovf;
        logic [15:0] d1, d2, eM, eA;

        // len, mode(0 none,1 one,2 two,3 at left start), d1, d2, left word main, left word alt, underruns, overflows
        vecs[0] = '{32, 1, 16'hA5C3, 16'h0000, 16'h0000, 16'h0000, 1, 0};
        vecs[1] = '{32, 1, 16'h1234, 16'h0000, 16'hA5C3, 16'hA5C3, 0, 0};
        vecs[2] = '{32, 0, 16'h0000, 16'h0000, 16'h1234, 16'h1234, 0, 0};
        vecs[3] = '{32, 2, 16'h1111, 16'h2222, 16'h1234, 16'h0000, 1, 1};
        vecs[4] = '{32, 1, 16'h8001, 16'h0000, 16'h1111, 16'h1111, 0, 0};
        vecs[5] = '{16, 0, 16'h0000, 16'h0000, 16'h8001, 16'h8001, 0, 0};
        vecs[6] = '{32, 3, 16'h7FFF, 16'h0000, 16'h8001, 16'h0000, 1, 0};
        vecs[7] = '{32, 3, 16'h5A5A, 16'h0000, 16'h7FFF, 16'h7FFF, 0, 0};
        vecs[8] = '{24, 1, 16'hFFFF, 16'h0000, 16'h5A5A, 16'h5A5A, 0, 0};
        lens = '{16, 20, 32};

        rst_n = 1'b0;
        repeat (4) @(negedge sclk);
        checkOutput("reset dout_main", dout_m, 0);
        checkOutput("reset dout_alt", dout_a, 0);
        checkOutput("reset frame_req", frame_req_m, 0);
        checkOutput("reset underrun", underrun_m, 0);
        checkOutput("reset overflow", overflow_m, 0);
        checkOutput("reset tx_ready_main", tx_ready_m, 1);
        checkOutput("reset tx_ready_alt", tx_ready_a, 1);
        rst_n = 1'b1;
        repeat (4) @(negedge sclk);

        // Arming slot: LRCK held high, no start event, line stays low
        runSlot(1'b1, 4, 16'h0, 16'h0, -1, 0, 16'h0, -1, 16'h0, -1);

        $display("[TB] directed frames");
        for (int i = 0; i < 9; i++) begin
            runFrame($sformatf("vec%0d", i), vecs[i].len, vecs[i].mode, vecs[i].d1, vecs[i].d2,
                     vecs[i].expM, vecs[i].expA, vecs[i].expUnd, vecs[i].expOvf);
        end

        $display("[TB] reset mid-word");
        un1M = unM;
        runSlot(1'b0, 32, 16'hFFFF, 16'hFFFF, 2, 5, 16'h0F0F, -1, 16'h0, 5);
        checkOutput("reset_slot underrun", unM - un1M, 0);
        fr1M = frM;
        fr1A = frA;
        runSlot(1'b1, 32, 16'h0, 16'h0, 4, 5, 16'hC3A5, -1, 16'h0, -1);
        checkOutput("no frame_req before second change main", frM - fr1M, 0);
        checkOutput("no frame_req before second change alt", frA - fr1A, 0);
        runFrame("post_reset", 32, 0, 16'h0, 16'h0, 16'hC3A5, 16'hC3A5, 0, 0);
        mHoldFull = 1'b0;
        mHold     = 16'h0;
        mLast     = 16'hC3A5;

        $display("[TB] randomized frames");
        for (int f = 0; f < 10; f++) begin
            mode = $urandom_range(0, 3);
            len  = lens[$urandom_range(0, 2)];
            d1   = 16'($urandom);
            d2   = 16'($urandom);
            und  = mHoldFull ? 0 : 1;
            eM   = mHoldFull ? mHold : mLast;
            eA   = mHoldFull ? mHold : 16'h0;
            if (mHoldFull) mLast = mHold;
            mHoldFull = 1'b0;
            ovf = 0;
            if (mode == 3) begin
                mHoldFull = 1'b1;
                mHold     = d1;
            end else if (mode >= 1) begin
                mHoldFull = 1'b1;
                mHold     = d1;
                if (mode == 2) ovf = 1;
            end
            runFrame($sformatf("rand%0d", f), len, mode, d1, d2, eM, eA, und, ovf);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
